// File: rtl/pc_fetch_unit_if.sv
// Fetch-unit bus: instruction-memory request/ack, control-unit select lines and
// the registered instruction/PC outputs, plus the FSM state for observation.
interface pc_fetch_unit_if;
  // imem handshake: imem_req stays high with imem_addr stable until imem_ack=1
  // is sampled on a rising clk; imem_ack is a single-cycle strobe carrying
  // imem_rdata and has no back-pressure.
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic        instr_valid;
  logic [2:0]  pcsel;
  logic [31:0] jt;
  logic        mem_busy;
  logic        irq_in;
  logic        irq;
  logic [31:0] pc;
  logic [31:0] pc_inc;
  logic [1:0]  fsm_state;

  modport master (
    output imem_req, imem_addr, instr, instr_valid, irq, pc, pc_inc, fsm_state,
    input  imem_ack, imem_rdata, pcsel, jt, mem_busy, irq_in
  );

  modport slave (
    input  imem_req, imem_addr, instr, instr_valid, irq, pc, pc_inc, fsm_state,
    output imem_ack, imem_rdata, pcsel, jt, mem_busy, irq_in
  );
endinterface

// File: rtl/pc_fetch_unit.sv
// Program counter and instruction fetch sequencer: IDLE -> FETCH -> EXEC loop,
// next-PC selection and supervisor-masked interrupt qualification.
module pc_fetch_unit (
  input  logic              clk,
  input  logic              reset_n,
  pc_fetch_unit_if.master   bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    EXEC  = 2'd2
  } state_t;

  localparam logic [31:0] RESET_PC = 32'h8000_0000;
  localparam logic [31:0] ILLOP_PC = 32'h8000_0004;
  localparam logic [31:0] IRQ_PC   = 32'h8000_0008;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] instr;
  logic        instr_valid;
  logic        imem_req;
  logic        irq_pending;
  logic [31:0] pc_inc;
  logic [31:0] br_off;
  logic [31:0] next_pc;
  logic        exec_exit;

  // Bit 31 is the supervisor flag; only the low 31 bits take part in arithmetic.
  assign pc_inc    = {pc[31], pc[30:0] + 31'd4};
  assign br_off    = {{14{instr[15]}}, instr[15:0], 2'b00};
  assign exec_exit = (state == EXEC) && !bus.mem_busy;

  always_comb begin
    next_pc = pc_inc;
    case (bus.pcsel)
      3'b000:  next_pc = pc_inc;
      3'b001:  next_pc = {pc[31], pc_inc[30:0] + br_off[30:0]};
      3'b010:  next_pc = {pc[31] & bus.jt[31], bus.jt[30:2], 2'b00};
      3'b011:  next_pc = ILLOP_PC;
      3'b100:  next_pc = IRQ_PC;
      default: next_pc = ILLOP_PC;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      instr       <= 32'h0;
      instr_valid <= 1'b0;
      imem_req    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          state    <= FETCH;
          imem_req <= 1'b1;
        end
        FETCH: begin
          if (bus.imem_ack) begin
            instr       <= bus.imem_rdata;
            imem_req    <= 1'b0;
            instr_valid <= 1'b1;
            state       <= EXEC;
          end
        end
        EXEC: begin
          if (!bus.mem_busy) begin
            pc          <= next_pc;
            imem_req    <= 1'b1;
            instr_valid <= 1'b0;
            state       <= FETCH;
          end
        end
        default: begin
          state       <= IDLE;
          imem_req    <= 1'b0;
          instr_valid <= 1'b0;
        end
      endcase
    end
  end

  // A new request in the same cycle as the IRQ-vector exit must survive.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq_pending <= 1'b0;
    end else if (bus.irq_in) begin
      irq_pending <= 1'b1;
    end else if (exec_exit && (bus.pcsel == 3'b100)) begin
      irq_pending <= 1'b0;
    end
  end

  assign bus.imem_req    = imem_req;
  assign bus.imem_addr   = pc;
  assign bus.instr       = instr;
  assign bus.instr_valid = instr_valid;
  assign bus.pc          = pc;
  assign bus.pc_inc      = pc_inc;
  assign bus.irq         = irq_pending & ~pc[31] & instr_valid;
  assign bus.fsm_state   = state;

endmodule

// File: doc/pc_fetch_unit.md
PC_FETCH_UNIT -- requirements
Module: pc_fetch_unit

Interface
REQ-001 SHALL have ports: CLK  in  1  clock, rising-edge; one clock only.
REQ-002 SHALL have RESET_N  in  1  reset, asynchronous, active-low.
REQ-003 SHALL have IMEM_REQ  out  1  instruction-memory read request.
REQ-004 SHALL have IMEM_ADDR  out  32  fetch address, equal to PC.
REQ-005 SHALL have IMEM_ACK  in  1  read data valid this cycle.
REQ-006 SHALL have IMEM_RDATA  in  32  instruction word, sampled when IMEM_ACK=1.
REQ-007 SHALL have INSTR  out  32  registered instruction presented to CU.
REQ-008 SHALL have INSTR_VALID  out  1  INSTR is in its execute cycle.
REQ-009 SHALL have PCSEL  in  3  next-PC select from CU: 000 +4, 001 branch, 010 JMP, 011 ILLOP, 100 IRQ.
REQ-010 SHALL have JT  in  32  jump target (register Ra data).
REQ-011 SHALL have MEM_BUSY  in  1  data memory stalls the execute cycle.
REQ-012 SHALL have IRQ_IN  in  1  external interrupt request, level or pulse.
REQ-013 SHALL have IRQ  out  1  qualified interrupt to CU.
REQ-014 SHALL have PC  out  32  current program counter; PC_INC  out  32  PC+4 for WDSEL=00 writeback.

Function
REQ-015 SHALL implement states IDLE, FETCH, EXEC.
REQ-016 IDLE SHALL move to FETCH on the first clock after reset release, setting IMEM_REQ=1.
REQ-017 In FETCH, IMEM_REQ SHALL be 1 and IMEM_ADDR SHALL hold PC stable until IMEM_ACK=1 is sampled.
REQ-018 On IMEM_ACK=1 in FETCH: INSTR<=IMEM_RDATA, IMEM_REQ<=0, state<=EXEC; INSTR_VALID=1 the next cycle (one-cycle ack-to-valid latency).
REQ-019 IMEM_ACK SHALL be ignored in IDLE and EXEC.
REQ-020 In EXEC with MEM_BUSY=1: state, PC, INSTR held; INSTR_VALID stays 1.
REQ-021 In EXEC with MEM_BUSY=0: PC<=next PC, state<=FETCH, IMEM_REQ<=1, INSTR_VALID<=0.
REQ-022 PC_INC SHALL equal {PC[31], PC[30:0]+4}; bit 31 (supervisor) never changed by carry.
REQ-023 Next PC for 000 SHALL be PC_INC.
REQ-024 For 001: {PC[31], PC_INC[30:0] + (sign-extended INSTR[15:0] << 2)}, bit 31 preserved, [30:0] wraps modulo 2^31.
REQ-025 For 010: {PC[31] & JT[31], JT[30:2], 2'b00} (JMP cannot enter supervisor mode).
REQ-026 For 011: 0x80000004; for 100: 0x80000008; for 101/110/111: 0x80000004.
REQ-027 PC[1:0] SHALL always be 00.
REQ-028 irq_pending SHALL set on any cycle with IRQ_IN=1 and clear on an EXEC exit with PCSEL=100; a simultaneous set and clear SHALL leave it set.
REQ-029 IRQ SHALL equal irq_pending & ~PC[31] & INSTR_VALID (masked in supervisor mode).

Reset
REQ-030 RESET_N=0 SHALL immediately force state=IDLE, PC=0x80000000, INSTR=0, INSTR_VALID=0, IMEM_REQ=0, irq_pending=0, IRQ=0.
REQ-031 Reset asserted mid-FETCH or mid-EXEC SHALL abort the operation; an ack arriving during or after reset, before the new FETCH, SHALL be discarded.

Verification
REQ-032 Reset release, ack 2 cycles after REQ with 0x80000000 data, PCSEL=000 -> IMEM_ADDR 0x80000000, then 0x80000004; INSTR_VALID 1 cycle after ack.
REQ-033 PC=0x00000100, INSTR[15:0]=0xFFFE, PCSEL=001 -> next PC 0x000000FC; INSTR[15:0]=0x0003 -> 0x00000110.
REQ-034 PC=0x00000040, JT=0x80000123, PCSEL=010 -> next PC 0x00000120; PC=0x80000040, same JT -> 0x80000120.
REQ-035 IRQ_IN pulse at PC=0x80000010 -> IRQ=0; after JMP to 0x00000200 -> IRQ=1 in EXEC; PCSEL=100 -> PC 0x80000008, irq_pending cleared.
REQ-036 MEM_BUSY=1 for 3 EXEC cycles -> PC/INSTR stable, INSTR_VALID=1, IMEM_REQ=0 throughout; MEM_BUSY=0 -> FETCH next cycle.
REQ-037 RESET_N pulsed low while IMEM_REQ=1, ack arrives during reset -> outputs at reset values, next fetch from 0x80000000.
